// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-controller bundle: hazard/handshake inputs from the pipeline and
// stall/flush controls, FSM state and performance counters back to it.
interface pipeline_hazard_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  logic [4:0]       raddr1_ID;
  logic [4:0]       raddr2_ID;
  logic             RS1Use_ID;
  logic             RS2Use_ID;
  logic [4:0]       waddr_EX;
  logic             RegWrite_EX;
  logic             Mem2Reg_EX;
  logic             redirect_EX;
  logic             dmem_req_MEM;
  logic             dmem_ready;
  logic             imem_ready;
  logic             clr_cnt;

  logic             PC_EN;
  logic             IF_ID_EN;
  logic             IF_ID_flush;
  logic             ID_EX_EN;
  logic             ID_EX_flush;
  logic             EX_MEM_EN;
  logic             MEM_WB_EN;
  logic [1:0]       state;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output raddr1_ID, raddr2_ID, RS1Use_ID, RS2Use_ID, waddr_EX, RegWrite_EX,
           Mem2Reg_EX, redirect_EX, dmem_req_MEM, dmem_ready, imem_ready, clr_cnt,
    input  PC_EN, IF_ID_EN, IF_ID_flush, ID_EX_EN, ID_EX_flush, EX_MEM_EN,
           MEM_WB_EN, state, mem_timeout, stall_cnt, flush_cnt
  );

  modport slave (
    input  raddr1_ID, raddr2_ID, RS1Use_ID, RS2Use_ID, waddr_EX, RegWrite_EX,
           Mem2Reg_EX, redirect_EX, dmem_req_MEM, dmem_ready, imem_ready, clr_cnt,
    output PC_EN, IF_ID_EN, IF_ID_flush, ID_EX_EN, ID_EX_flush, EX_MEM_EN,
           MEM_WB_EN, state, mem_timeout, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the five-stage pipeline: Mealy control outputs,
// data-memory wait FSM with sticky timeout, saturating stall/flush counters.
module pipeline_hazard_ctrl #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  pipeline_hazard_ctrl_if.slave hz
);

  localparam int unsigned WW = $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0]    WMAX = WW'(TIMEOUT);
  localparam logic [CNT_W-1:0] CMAX = '1;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DWAIT = 2'd1
  } state_e;

  state_e           state_q, state_d;
  logic [WW-1:0]    wait_cnt_q, wait_cnt_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;

  logic data_wait;
  logic load_use;
  logic redirect_apply;

  assign data_wait = hz.dmem_req_MEM & ~hz.dmem_ready;
  assign load_use  = hz.Mem2Reg_EX & hz.RegWrite_EX & (hz.waddr_EX != 5'd0) &
                     ((hz.RS1Use_ID & (hz.raddr1_ID == hz.waddr_EX)) |
                      (hz.RS2Use_ID & (hz.raddr2_ID == hz.waddr_EX)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= RUN;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:     if (data_wait)     state_d = DWAIT;
      DWAIT:   if (hz.dmem_ready) state_d = RUN;
      default:                    state_d = RUN;
    endcase
  end

  // Priority: data wait > redirect > load-use > fetch wait; reset gates all to 0.
  always_comb begin
    hz.PC_EN       = 1'b1;
    hz.IF_ID_EN    = 1'b1;
    hz.IF_ID_flush = 1'b0;
    hz.ID_EX_EN    = 1'b1;
    hz.ID_EX_flush = 1'b0;
    hz.EX_MEM_EN   = 1'b1;
    hz.MEM_WB_EN   = 1'b1;
    redirect_apply = 1'b0;
    if (!rst || data_wait) begin
      hz.PC_EN     = 1'b0;
      hz.IF_ID_EN  = 1'b0;
      hz.ID_EX_EN  = 1'b0;
      hz.EX_MEM_EN = 1'b0;
      hz.MEM_WB_EN = 1'b0;
    end else if (hz.redirect_EX) begin
      hz.IF_ID_flush = 1'b1;
      hz.ID_EX_flush = 1'b1;
      redirect_apply = 1'b1;
    end else if (load_use) begin
      hz.PC_EN       = 1'b0;
      hz.IF_ID_EN    = 1'b0;
      hz.ID_EX_flush = 1'b1;
    end else if (!hz.imem_ready) begin
      hz.PC_EN       = 1'b0;
      hz.IF_ID_flush = 1'b1;
    end
  end

  always_comb begin
    wait_cnt_d = '0;
    timeout_d  = timeout_q;
    if (state_q == DWAIT) begin
      wait_cnt_d = (wait_cnt_q == WMAX) ? wait_cnt_q : wait_cnt_q + 1'b1;
      if (wait_cnt_q == WMAX) timeout_d = 1'b1;
    end

    stall_d = stall_q;
    flush_d = flush_q;
    if (hz.clr_cnt) begin
      stall_d = '0;
      flush_d = '0;
    end else begin
      if (!hz.PC_EN && (stall_q != CMAX))   stall_d = stall_q + 1'b1;
      if (redirect_apply && (flush_q != CMAX)) flush_d = flush_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
      stall_q    <= '0;
      flush_q    <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
      stall_q    <= stall_d;
      flush_q    <= flush_d;
    end
  end

  assign hz.state       = state_q;
  assign hz.mem_timeout = timeout_q;
  assign hz.stall_cnt   = stall_q;
  assign hz.flush_cnt   = flush_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl with small TIMEOUT/CNT_W so the
// timeout and counter saturation are reachable quickly.
module tb_pipeline_hazard_ctrl;

  localparam int unsigned TO   = 4;
  localparam int unsigned CW   = 4;
  localparam int          MAXC = (1 << CW) - 1;

  logic clk;
  logic rst;

  pipeline_hazard_ctrl_if #(.CNT_W(CW)) bus ();

  pipeline_hazard_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] ctrl;
    int         st;
    int         to;
    int         sc;
    int         fc;
  } exp_t;

  exp_t q[$];

  int n_chk = 0;
  int n_bad = 0;

  int m_st, m_w, m_to, m_sc, m_fc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] ctrl_now();
    return {bus.PC_EN, bus.IF_ID_EN, bus.IF_ID_flush, bus.ID_EX_EN,
            bus.ID_EX_flush, bus.EX_MEM_EN, bus.MEM_WB_EN};
  endfunction

  task automatic model_reset();
    m_st = 0; m_w = 0; m_to = 0; m_sc = 0; m_fc = 0;
    q.delete();
  endtask

  task automatic idle();
    bus.raddr1_ID    = 5'd0;
    bus.raddr2_ID    = 5'd0;
    bus.RS1Use_ID    = 1'b0;
    bus.RS2Use_ID    = 1'b0;
    bus.waddr_EX     = 5'd0;
    bus.RegWrite_EX  = 1'b0;
    bus.Mem2Reg_EX   = 1'b0;
    bus.redirect_EX  = 1'b0;
    bus.dmem_req_MEM = 1'b0;
    bus.dmem_ready   = 1'b1;
    bus.imem_ready   = 1'b1;
    bus.clr_cnt      = 1'b0;
  endtask

  // Called at posedge+1 with inputs already driven; leaves at next posedge+1.
  task automatic step();
    exp_t e, o;
    logic fz, lu, rd;
    logic [6:0] c;
    fz = bus.dmem_req_MEM && !bus.dmem_ready;
    lu = bus.Mem2Reg_EX && bus.RegWrite_EX && (bus.waddr_EX != 0) &&
         ((bus.RS1Use_ID && bus.raddr1_ID == bus.waddr_EX) ||
          (bus.RS2Use_ID && bus.raddr2_ID == bus.waddr_EX));
    rd = 1'b0;
    // bit order: PC, IF_ID_EN, IF_ID_flush, ID_EX_EN, ID_EX_flush, EX_MEM, MEM_WB
    if (fz)                   c = 7'b0000000;
    else if (bus.redirect_EX) begin c = 7'b1111111; rd = 1'b1; end
    else if (lu)              c = 7'b0001111;
    else if (!bus.imem_ready) c = 7'b0111011;
    else                      c = 7'b1101011;
    e.ctrl = c; e.st = m_st; e.to = m_to; e.sc = m_sc; e.fc = m_fc;
    q.push_back(e);

    @(negedge clk);
    o = q.pop_front();
    chk("ctrl",      32'(ctrl_now()),       32'(o.ctrl));
    chk("state",     32'(bus.state),        32'(o.st));
    chk("timeout",   32'(bus.mem_timeout),  32'(o.to));
    chk("stall_cnt", 32'(bus.stall_cnt),    32'(o.sc));
    chk("flush_cnt", 32'(bus.flush_cnt),    32'(o.fc));

    @(posedge clk);
    if (m_st == 1) begin
      if (m_w == int'(TO)) m_to = 1;
      if (m_w < int'(TO)) m_w++;
    end else begin
      m_w = 0;
    end
    if (m_st == 0) m_st = fz ? 1 : 0;
    else if (bus.dmem_ready) m_st = 0;
    if (bus.clr_cnt) begin
      m_sc = 0; m_fc = 0;
    end else begin
      if (!c[6] && m_sc < MAXC) m_sc++;
      if (rd && m_fc < MAXC) m_fc++;
    end
    #1;
  endtask

  task automatic load_use_setup(input logic [4:0] wa, input logic u1);
    bus.Mem2Reg_EX  = 1'b1;
    bus.RegWrite_EX = 1'b1;
    bus.waddr_EX    = wa;
    bus.RS1Use_ID   = u1;
    bus.raddr1_ID   = 5'd5;
  endtask

  task automatic clr_step();
    idle();
    bus.clr_cnt = 1'b1;
    step();
    idle();
  endtask

  initial begin
    model_reset();
    idle();
    rst = 1'b0;
    #12;
    chk("rst_ctrl",  32'(ctrl_now()),      32'd0);
    chk("rst_state", 32'(bus.state),       32'd0);
    chk("rst_cnt",   32'(bus.stall_cnt),   32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    step();

    // Load-use on rs1, then the two non-hazard variants.
    load_use_setup(5'd5, 1'b1);
    step();
    chk("lu_stall", 32'(bus.stall_cnt), 32'd1);
    load_use_setup(5'd0, 1'b1);
    bus.raddr1_ID = 5'd0;
    step();
    load_use_setup(5'd5, 1'b0);
    step();
    chk("lu_none", 32'(bus.stall_cnt), 32'd1);

    // Redirect wins over a simultaneous load-use.
    clr_step();
    load_use_setup(5'd5, 1'b1);
    bus.redirect_EX = 1'b1;
    step();
    chk("rd_flush", 32'(bus.flush_cnt), 32'd1);
    chk("rd_stall", 32'(bus.stall_cnt), 32'd0);

    // Three-cycle data wait with a redirect pending throughout.
    clr_step();
    bus.dmem_req_MEM = 1'b1;
    bus.dmem_ready   = 1'b0;
    bus.redirect_EX  = 1'b1;
    repeat (3) step();
    chk("dw_state", 32'(bus.state), 32'd1);
    bus.dmem_ready = 1'b1;
    step();
    chk("dw_stall", 32'(bus.stall_cnt), 32'd3);
    chk("dw_flush", 32'(bus.flush_cnt), 32'd1);
    chk("dw_run",   32'(bus.state),     32'd0);

    // Fetch wait long enough to saturate stall_cnt.
    clr_step();
    bus.imem_ready = 1'b0;
    repeat (20) step();
    chk("sat", 32'(bus.stall_cnt), 32'(MAXC));
    clr_step();
    chk("clr", 32'(bus.stall_cnt), 32'd0);

    // Timeout: one entry edge plus TO+1 edges spent in DWAIT.
    idle();
    bus.dmem_req_MEM = 1'b1;
    bus.dmem_ready   = 1'b0;
    repeat (TO + 2) step();
    chk("to_set", 32'(bus.mem_timeout), 32'd1);
    bus.dmem_ready = 1'b1;
    step();
    chk("to_sticky", 32'(bus.mem_timeout), 32'd1);
    chk("to_run",    32'(bus.state),       32'd0);

    // Asynchronous reset in the middle of a data wait.
    idle();
    bus.dmem_req_MEM = 1'b1;
    bus.dmem_ready   = 1'b0;
    bus.redirect_EX  = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    #1;
    chk("ar_state", 32'(bus.state),       32'd0);
    chk("ar_to",    32'(bus.mem_timeout), 32'd0);
    chk("ar_stall", 32'(bus.stall_cnt),   32'd0);
    chk("ar_flush", 32'(bus.flush_cnt),   32'd0);
    chk("ar_ctrl",  32'(ctrl_now()),      32'd0);
    model_reset();
    idle();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    step();
    chk("ar_idle", 32'(ctrl_now()), 32'h6B);

    // Random traffic against the model.
    for (int i = 0; i < 120; i++) begin
      bus.raddr1_ID    = 5'($urandom_range(0, 3));
      bus.raddr2_ID    = 5'($urandom_range(0, 3));
      bus.RS1Use_ID    = 1'($urandom);
      bus.RS2Use_ID    = 1'($urandom);
      bus.waddr_EX     = 5'($urandom_range(0, 3));
      bus.RegWrite_EX  = 1'($urandom);
      bus.Mem2Reg_EX   = 1'($urandom);
      bus.redirect_EX  = ($urandom_range(0, 3) == 0);
      bus.dmem_req_MEM = 1'($urandom);
      bus.dmem_ready   = ($urandom_range(0, 9) < 7);
      bus.imem_ready   = ($urandom_range(0, 3) != 0);
      bus.clr_cnt      = ($urandom_range(0, 19) == 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1);
  end

endmodule
